// File: rtl/q_8_34d_dp_pkg.sv
// Shared definitions for the ones-counter controller/datapath pair.
// Holds the default datapath width and the command bundle the controller
// hands to the datapath each cycle.
package q_8_34d_dp_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    // One command word per cycle; load_regs has priority over the other two.
    typedef struct packed {
        logic load_regs;
        logic incr_r2;
        logic shift;
    } q_8_34d_cmd_t;

endpackage

// File: rtl/q_8_34d_dp_if.sv
// Controller <-> datapath bus for the ones counter.
//   master : the controller; drives commands and data_in, observes status.
//   slave  : the datapath; consumes commands, returns zero/E/count/r1.
// Signals: load_regs, incr_r2, shift, data_in[WIDTH] (commands);
//          zero, E, count[WIDTH], r1[WIDTH] (status).
interface q_8_34d_dp_if
    import q_8_34d_dp_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic             load_regs;
    logic             incr_r2;
    logic             shift;
    logic [WIDTH-1:0] data_in;
    logic             zero;
    logic             E;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] r1;

    modport master (
        output load_regs, incr_r2, shift, data_in,
        input  zero, E, count, r1
    );

    modport slave (
        input  load_regs, incr_r2, shift, data_in,
        output zero, E, count, r1
    );
endinterface

// File: rtl/d_ff.sv
// Generic resettable D flip-flop bank.
//   clk_i     : rising-edge clock
//   rst_ni    : asynchronous active-low reset, loads RESET_VAL
//   d_i / q_o : data in / registered data out
module d_ff #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= RESET_VAL;
        end else begin
            q_o <= d_i;
        end
    end
endmodule

// File: rtl/q_8_34d_dp.sv
// Ones-counter datapath. R1 holds the operand being shifted out, R2 counts
// the ones seen, E catches each bit leaving R1[WIDTH-1].
//   clk   : rising-edge clock
//   rst_b : asynchronous active-low reset (R1 = R2 = E = 0)
//   bus   : slave side of q_8_34d_dp_if (commands in, zero/E/count/r1 out)
module q_8_34d_dp
    import q_8_34d_dp_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_b,
    q_8_34d_dp_if.slave  bus
);
    q_8_34d_cmd_t     cmd;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [WIDTH-1:0] r2_q, r2_d;
    logic             e_q, e_d;

    assign cmd = '{load_regs: bus.load_regs, incr_r2: bus.incr_r2, shift: bus.shift};

    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        e_d  = e_q;
        if (cmd.load_regs) begin
            r1_d = bus.data_in;
            // Preset to -1 so the controller's unconditional first increment lands on 0.
            r2_d = '1;
            e_d  = 1'b0;
        end else begin
            // Shift and increment are independent and may fire on the same edge.
            if (cmd.shift) begin
                e_d  = r1_q[WIDTH-1];
                r1_d = {r1_q[WIDTH-2:0], 1'b0};
            end
            if (cmd.incr_r2) begin
                r2_d = r2_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r1_q <= '0;
            r2_q <= '0;
        end else begin
            r1_q <= r1_d;
            r2_q <= r2_d;
        end
    end

    d_ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_e_ff (
        .clk_i  (clk),
        .rst_ni (rst_b),
        .d_i    (e_d),
        .q_o    (e_q)
    );

    assign bus.zero  = (r1_q == '0);
    assign bus.E     = e_q;
    assign bus.count = r2_q;
    assign bus.r1    = r1_q;
endmodule

// File: tb/tb_q_8_34d_dp.sv
module tb_q_8_34d_dp;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   total = 0;
    int   bad = 0;

    q_8_34d_dp_if #(.WIDTH(8)) if8 ();
    q_8_34d_dp_if #(.WIDTH(4)) if4 ();

    q_8_34d_dp #(.WIDTH(8)) dut8 (.clk(clk), .rst_b(rst_b), .bus(if8));
    q_8_34d_dp #(.WIDTH(4)) dut4 (.clk(clk), .rst_b(rst_b), .bus(if4));

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w4, input logic l, input logic i, input logic s,
                         input logic [7:0] d);
        if (w4) begin
            if4.load_regs = l; if4.incr_r2 = i; if4.shift = s; if4.data_in = d[3:0];
        end else begin
            if8.load_regs = l; if8.incr_r2 = i; if8.shift = s; if8.data_in = d;
        end
    endtask

    function automatic logic get_e(input bit w4);
        return w4 ? if4.E : if8.E;
    endfunction

    function automatic logic get_zero(input bit w4);
        return w4 ? if4.zero : if8.zero;
    endfunction

    function automatic logic [7:0] get_count(input bit w4);
        return w4 ? {4'h0, if4.count} : if8.count;
    endfunction

    // Checks the 8-bit instance's four status outputs against expected values.
    task automatic chk8(input string name, input logic [7:0] er1, input logic [7:0] ecnt,
                        input logic ee);
        logic ez;
        ez = (er1 == 8'h00);
        total++;
        if (if8.r1 !== er1 || if8.count !== ecnt || if8.E !== ee || if8.zero !== ez) begin
            bad++;
            $display("FAIL %s: got r1=%h count=%h E=%b zero=%b, want r1=%h count=%h E=%b zero=%b",
                     name, if8.r1, if8.count, if8.E, if8.zero, er1, ecnt, ee, ez);
        end
    endtask

    // Controller: load, then incr -> shift -> (E ? incr : zero ? idle : shift).
    // data_in is scrambled on every non-load cycle; it must be ignored.
    task automatic run_loop(input bit w4, input logic [7:0] v, output logic [7:0] cnt,
                            output bit ok);
        int  phase;
        int  steps;
        bit  done;
        drive(w4, 1'b1, 1'b0, 1'b0, v);
        cycle();
        phase = 0;
        steps = 0;
        done  = 1'b0;
        ok    = 1'b0;
        while (!done && steps < 200) begin
            steps++;
            if (phase == 0) begin
                drive(w4, 1'b0, 1'b1, 1'b0, 8'($urandom));
                cycle();
                phase = 1;
            end else if (phase == 1) begin
                drive(w4, 1'b0, 1'b0, 1'b1, 8'($urandom));
                cycle();
                phase = 2;
            end else begin
                drive(w4, 1'b0, 1'b0, 1'b0, 8'($urandom));
                if (get_e(w4)) phase = 0;
                else if (get_zero(w4)) begin
                    ok = 1'b1;
                    done = 1'b1;
                end else phase = 1;
            end
        end
        drive(w4, 1'b0, 1'b0, 1'b0, 8'h00);
        cnt = get_count(w4);
    endtask

    task automatic loop_check(input bit w4, input logic [7:0] v);
        logic [7:0] cnt;
        logic [7:0] exp;
        bit         ok;
        exp = w4 ? 8'($countones(v[3:0])) : 8'($countones(v));
        run_loop(w4, v, cnt, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL loop_timeout w4=%0d v=%h: controller never reached idle", w4, v);
        end else if (cnt !== exp) begin
            bad++;
            $display("FAIL popcount w4=%0d v=%h: got count=%0d, want %0d", w4, v, cnt, exp);
        end
    endtask

    task automatic test_reset();
        total++;
        if (if8.r1 !== 8'h00 || if8.count !== 8'h00 || if8.E !== 1'b0 || if8.zero !== 1'b1 ||
            if4.r1 !== 4'h0 || if4.count !== 4'h0 || if4.E !== 1'b0 || if4.zero !== 1'b1) begin
            bad++;
            $display("FAIL reset: got r1=%h count=%h E=%b zero=%b, want 00 00 0 1",
                     if8.r1, if8.count, if8.E, if8.zero);
        end
    endtask

    task automatic test_load();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hB5);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk8("load_b5", 8'hB5, 8'hFF, 1'b0);
    endtask

    task automatic test_closed_loop();
        logic [7:0] pats [4] = '{8'hB5, 8'hFF, 8'h00, 8'h80};
        foreach (pats[k]) loop_check(1'b0, pats[k]);
        for (int k = 0; k < 6; k++) loop_check(1'b0, 8'($urandom));
    endtask

    task automatic test_shift();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h81);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hAA);
        cycle();
        chk8("shift1", 8'h02, 8'hFF, 1'b1);
        cycle();
        chk8("shift2", 8'h04, 8'hFF, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk8("shift_zero", 8'h00, 8'hFF, 1'b0);
    endtask

    task automatic test_incr_priority();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        chk8("incr_wrap", 8'h11, 8'h00, 1'b0);
        // Leave E set so the load is seen clearing it.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
        cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        cycle();
        chk8("incr_and_shift", 8'h00, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk8("load_priority", 8'h3C, 8'hFF, 1'b0);
        cycle();
        chk8("hold", 8'h3C, 8'hFF, 1'b0);
    endtask

    // Random commands against an arithmetic model of R1/R2/E.
    task automatic test_random();
        int m_r1, m_r2, m_e;
        logic l, i, s;
        logic [7:0] d;
        m_r1 = 0; m_r2 = 0; m_e = 0;
        for (int n = 0; n < 150; n++) begin
            l = (n == 0) || ($urandom_range(7) == 0);
            i = 1'($urandom);
            s = 1'($urandom);
            d = 8'($urandom);
            drive(1'b0, l, i, s, d);
            cycle();
            if (l) begin
                m_r1 = int'(d); m_r2 = 255; m_e = 0;
            end else begin
                if (s) begin
                    m_e  = (m_r1 >= 128) ? 1 : 0;
                    m_r1 = (m_r1 * 2) % 256;
                end
                if (i) m_r2 = (m_r2 + 1) % 256;
            end
            chk8("random", 8'(m_r1), 8'(m_r2), 1'(m_e));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle();
        #2;
        rst_b = 1'b0;
        #1;
        chk8("async_reset", 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle();
        rst_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if8.data_in = 8'($urandom);
            cycle();
            chk8("post_reset_hold", 8'h00, 8'h00, 1'b0);
        end
        // Release reset mid-cycle with a load pending.
        #2;
        rst_b = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
        #2;
        rst_b = 1'b1;
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk8("release_with_load", 8'h5A, 8'hFF, 1'b0);
    endtask

    task automatic test_width4();
        loop_check(1'b1, 8'h0D);
        loop_check(1'b1, 8'h0F);
        loop_check(1'b1, 8'h00);
        for (int k = 0; k < 4; k++) loop_check(1'b1, 8'($urandom));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        #3;
        test_reset();
        cycle();
        rst_b = 1'b1;
        cycle();
        test_reset();
        test_load();
        test_closed_loop();
        test_shift();
        test_incr_priority();
        test_random();
        test_reset_mid();
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/q_8_34d_dp.md
Q_8_34D_DP -- requirements
Module: q_8_34d_dp

Interface
REQ-001 Parameter: WIDTH, default 8, width of R1 and R2 in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_b  input  1  asynchronous active-low reset.
REQ-004 load_regs  input  1  command: load R1 from data_in and preset R2 to all-ones.
REQ-005 incr_r2  input  1  command: increment R2 by one.
REQ-006 shift  input  1  command: shift {E,R1} left by one, zero-filling R1[0].
REQ-007 data_in  input  WIDTH  operand whose set bits are counted.
REQ-008 zero  output  1  high when R1 == 0; combinational from R1 only.
REQ-009 E  output  1  carry-out flop holding the last bit shifted out of R1[WIDTH-1].
REQ-010 count  output  WIDTH  current R2 value (ones count once the controller is idle).
REQ-011 r1  output  WIDTH  current R1 value, for debug and verification.

Function
REQ-012 The block SHALL be the datapath answering the one-hot ones-counter controller: it consumes load_regs/incr_r2/shift and returns zero/E.
REQ-013 load_regs=1 at an edge: R1 <= data_in; R2 <= all-ones; E <= 0.
REQ-014 shift=1 (load_regs=0) at an edge: E <= R1[WIDTH-1]; R1 <= {R1[WIDTH-2:0],1'b0}.
REQ-015 incr_r2=1 (load_regs=0) at an edge: R2 <= R2 + 1 modulo 2^WIDTH; all-ones wraps to 0 with no flag.
REQ-016 Priority: load_regs overrides incr_r2 and shift in the same cycle.
REQ-017 incr_r2 and shift asserted together without load_regs: both SHALL take effect in the same edge.
REQ-018 No command asserted: R1, R2 and E hold.
REQ-019 Latency: each command SHALL be visible on the outputs one clock after the sampling edge; zero SHALL track R1 with no extra cycle.
REQ-020 Shift with R1 == 0: R1 stays 0 and E <= 0.
REQ-021 Closed-loop result: with the controller sequence, count SHALL equal popcount(data_in) when the controller returns to idle; data_in == 0 gives count == 0.
REQ-022 data_in SHALL be sampled only on load_regs; changes at any other time SHALL have no effect.

Reset
REQ-023 rst_b low SHALL immediately force R1=0, R2=0 and E=0, so zero=1 and count=0, regardless of clk.
REQ-024 Reset asserted mid-count SHALL discard the operation; after release the block holds reset values until the next load_regs.
REQ-025 Reset release coincident with an active command: the first rising edge after rst_b is high SHALL apply that command normally.

Structure
REQ-026 A shared package SHALL hold the WIDTH default constant and a q_8_34d_cmd_t struct {load_regs, incr_r2, shift}, for controller/datapath top-level use.
REQ-027 The E flop SHALL reuse the codebase's d_ff with RESET_VAL = 0; R1 and R2 are inline always_ff registers; no other sub-module.
REQ-028 Target size 120-200 lines of RTL; no latches; a single always_ff per register group.

Verification
REQ-029 Load 8'hB5 -> r1=8'hB5, count=8'hFF, E=0, zero=0 one cycle later.
REQ-030 Load 8'hB5, then drive the controller sequence (incr, shift, E check) until zero=1 -> count=5 at idle; repeat with 8'hFF -> count=8, 8'h00 -> count=0, 8'h80 -> count=1.
REQ-031 r1=8'h81 with shift alone -> r1=8'h02, E=1; second shift -> r1=8'h04, E=0.
REQ-032 count=8'hFF with incr_r2 -> count=8'h00; load_regs+incr_r2+shift together with data_in=8'h3C -> r1=8'h3C, count=8'hFF, E=0.
REQ-033 Assert rst_b low between clock edges mid-count -> r1=0, count=0, E=0, zero=1 immediately; no change until the next load_regs.
REQ-034 WIDTH=4 instance, data_in=4'hD -> count=3 via the same closed-loop sequence.
